// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART-to-RAM boot loader.
package loader_pkg;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} sess_state_t;

  // Clock cycles per UART bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clkrate, input int unsigned baud);
    return clkrate / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser; emits one-cycle byte and frame-error strobes.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       line_idle
);

  localparam int unsigned CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [1:0]    sync;
  logic          rx_q;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= 2'b11;
      rx_q       <= 1'b1;
      state      <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      brk        <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      line_idle  <= 1'b1;
    end else begin
      sync       <= {sync[0], rx};
      rx_q       <= sync[1];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        R_IDLE: begin
          if (rx_q && !sync[1]) begin
            state     <= R_START;
            cnt       <= '0;
            line_idle <= 1'b0;
          end
        end
        R_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (sync[1]) begin
              state     <= R_IDLE;
              line_idle <= 1'b1;
            end else begin
              state <= R_DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shift   <= {sync[1], shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= R_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_STOP: begin
          // After a bad stop bit, hold here until the line returns high.
          if (brk) begin
            if (sync[1]) begin
              brk       <= 1'b0;
              state     <= R_IDLE;
              line_idle <= 1'b1;
            end
          end else if (cnt == FULL) begin
            cnt <= '0;
            if (sync[1]) begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
              state      <= R_IDLE;
              line_idle  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_loader.sv
// Session control: packs received bytes into little-endian words and writes them to RAM while owning the bus.
module uart_bus_loader
  import loader_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CLKRATE = 25_000_000,
  parameter int unsigned BAUD    = 115_200,
  parameter int unsigned BASE    = 50_000,
  parameter int unsigned NWORDS  = 1024,
  parameter int unsigned GAPBITS = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             arm,
  output logic             bus_own,
  output logic             enw,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] wdata,
  output logic             done,
  output logic             frame_err,
  output logic [15:0]      word_count
);

  localparam int unsigned DIV = baud_div(CLKRATE, BAUD);
  localparam int unsigned GAP = GAPBITS * DIV;
  localparam int unsigned TW  = $clog2(GAP) + 1;

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          rx_ferr;
  logic          line_idle;
  sess_state_t   state;
  logic [1:0]    lane;
  logic [23:0]   partial;
  logic [TW-1:0] gap_cnt;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (rx_ferr),
    .line_idle (line_idle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lane       <= '0;
      partial    <= '0;
      gap_cnt    <= '0;
      bus_own    <= 1'b0;
      enw        <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      enw <= 1'b0;
      if (rx_ferr) frame_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (arm) begin
            state      <= S_LOAD;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            word_count <= '0;
            lane       <= '0;
            partial    <= '0;
            gap_cnt    <= '0;
            bus_own    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (rx_ferr) begin
            lane    <= '0;
            partial <= '0;
            gap_cnt <= '0;
          end else if (byte_valid) begin
            gap_cnt <= '0;
            if (lane == 2'd3) begin
              enw     <= 1'b1;
              address <= WIDTH'(BASE) + WIDTH'(word_count);
              wdata   <= WIDTH'({rx_byte, partial});
              state   <= S_WRITE;
            end else begin
              partial[8*lane +: 8] <= rx_byte;
              lane                 <= lane + 2'd1;
            end
          end else if (lane != 2'd0 && line_idle) begin
            // A stalled partial word is dropped silently after the idle gap.
            if (gap_cnt == TW'(GAP - 1)) begin
              lane    <= '0;
              partial <= '0;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + TW'(1);
            end
          end else begin
            gap_cnt <= '0;
          end
        end
        S_WRITE: begin
          lane    <= '0;
          partial <= '0;
          if (word_count + 16'd1 >= 16'(NWORDS)) begin
            word_count <= 16'(NWORDS);
            state      <= S_DONE;
            done       <= 1'b1;
            bus_own    <= 1'b0;
          end else begin
            word_count <= word_count + 16'd1;
            state      <= S_LOAD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
